// File: rtl/mioc_pkg.sv
// Shared types and helpers for the mioc_ws memory/IO controller.
// Holds the FSM state encoding, the default IO page and error word, and a clog2 helper.
package mioc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mioc_state_e;

  localparam logic [3:0]  IO_PAGE_DEF  = 4'h7;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (int'(32'd1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mioc_wait_ctr.sv
// ACCESS-cycle counter for mioc_ws: saturating, with clear and enable.
// Flags when the minimum wait has elapsed and when the timeout cycle is reached.
module mioc_wait_ctr
  import mioc_pkg::*;
#(
  parameter int MIN_WAIT = 1,
  parameter int TIMEOUT  = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic min_reached,
  output logic timed_out
);

  localparam int CW = clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MIN_C  = CW'(MIN_WAIT);
  localparam logic [CW-1:0] LAST_C = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] SAT_C  = {CW{1'b1}};

  logic [CW-1:0] cnt_r;

  // Count ACCESS cycles, holding at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en && (cnt_r != SAT_C)) begin
      cnt_r <= cnt_r + ONE_C;
    end
  end

  assign min_reached = (cnt_r >= MIN_C);
  assign timed_out   = (cnt_r == LAST_C);

endmodule

// File: rtl/mioc_ws.sv
// Memory/IO controller: combinational RAM pass-through plus an IO path with a
// registered request/ready handshake, minimum wait states, timeout and bad-channel error.
module mioc_ws
  import mioc_pkg::*;
#(
  parameter int          AW       = 32,
  parameter int          DW       = 32,
  parameter int          NUM_CH   = 4,
  parameter int          CH_LSB   = 8,
  parameter logic [3:0]  IO_PAGE  = IO_PAGE_DEF,
  parameter int          MIN_WAIT = 1,
  parameter int          TIMEOUT  = 64,
  parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 memCe,
  input  logic                 memWr,
  input  logic [AW-1:0]        memAddr,
  input  logic [DW-1:0]        wtData,
  output logic [DW-1:0]        rdData,
  output logic                 memStall,
  output logic                 memErr,
  output logic                 ramCe,
  output logic                 ramWe,
  output logic [AW-1:0]        ramAddr,
  output logic [DW-1:0]        ramWtData,
  input  logic [DW-1:0]        ramRdData,
  output logic [NUM_CH-1:0]    ioCe,
  output logic                 ioWe,
  output logic [AW-1:0]        ioAddr,
  output logic [DW-1:0]        ioWtData,
  input  logic [NUM_CH*DW-1:0] ioRdData,
  input  logic [NUM_CH-1:0]    ioRdy
);

  localparam int CHW = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam logic [CHW:0] NUM_CH_C = (CHW + 1)'(NUM_CH);

  mioc_state_e state_r, state_nxt_s;

  logic            io_hit_s, ram_hit_s, ch_bad_s;
  logic [CHW-1:0]  ch_s, ch_r;
  logic [AW-1:0]   addr_r;
  logic [DW-1:0]   wdata_r, rd_r, rd_sel_s;
  logic            we_r, err_r;
  logic            rdy_sel_s, min_reached_s, timed_out_s, cnt_clr_s, cnt_en_s;
  logic [DW-1:0]   ch_rd_s [NUM_CH];

  assign io_hit_s  = memCe && (memAddr[AW-1 -: 4] == IO_PAGE);
  assign ram_hit_s = memCe && !io_hit_s;
  assign ch_s      = memAddr[CH_LSB +: CHW];
  assign ch_bad_s  = ({1'b0, ch_s} >= NUM_CH_C);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch_rd
    assign ch_rd_s[k] = ioRdData[k*DW +: DW];
  end

  assign rdy_sel_s = ioRdy[ch_r];
  assign rd_sel_s  = ch_rd_s[ch_r];

  mioc_wait_ctr #(
    .MIN_WAIT (MIN_WAIT),
    .TIMEOUT  (TIMEOUT)
  ) u_wait_ctr (
    .clk         (clk),
    .rst         (rst),
    .clr         (cnt_clr_s),
    .en          (cnt_en_s),
    .min_reached (min_reached_s),
    .timed_out   (timed_out_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state plus all CPU/RAM/IO facing outputs.
  always_comb begin
    state_nxt_s = state_r;
    cnt_clr_s   = 1'b1;
    cnt_en_s    = 1'b0;
    memStall    = 1'b0;
    memErr      = 1'b0;
    ioCe        = {NUM_CH{1'b0}};
    ioWe        = 1'b0;
    ioAddr      = {AW{1'b0}};
    ioWtData    = {DW{1'b0}};
    ramCe       = ram_hit_s;
    ramWe       = ram_hit_s & memWr;
    ramAddr     = ram_hit_s ? memAddr : {AW{1'b0}};
    ramWtData   = wtData;
    rdData      = {DW{1'b0}};
    case (state_r)
      IDLE: begin
        memStall = io_hit_s;
        if (io_hit_s) begin
          state_nxt_s = ch_bad_s ? DONE : ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
        if (ram_hit_s) begin
          rdData = ramRdData;
        end else begin
          rdData = {DW{1'b0}};
        end
      end
      ACCESS: begin
        cnt_clr_s    = 1'b0;
        cnt_en_s     = 1'b1;
        memStall     = 1'b1;
        ioCe[ch_r]   = 1'b1;
        ioWe         = we_r;
        ioAddr       = addr_r;
        ioWtData     = wdata_r;
        if ((min_reached_s && rdy_sel_s) || timed_out_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = ACCESS;
        end
        if (ram_hit_s) begin
          rdData = ramRdData;
        end else begin
          rdData = {DW{1'b0}};
        end
      end
      DONE: begin
        rdData      = rd_r;
        memErr      = err_r;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    // Nothing but the pure RAM strobes may escape while reset is held.
    if (rst) begin
      memStall = 1'b0;
      rdData   = {DW{1'b0}};
    end else begin
      memStall = memStall;
    end
  end

  // Latch the IO request in IDLE and capture its completion result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r  <= {AW{1'b0}};
      wdata_r <= {DW{1'b0}};
      we_r    <= 1'b0;
      ch_r    <= {CHW{1'b0}};
      err_r   <= 1'b0;
      rd_r    <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (io_hit_s) begin
            addr_r  <= memAddr;
            wdata_r <= wtData;
            we_r    <= memWr;
            ch_r    <= ch_s;
            err_r   <= ch_bad_s;
            rd_r    <= ch_bad_s ? ERR_DATA : {DW{1'b0}};
          end
        end
        ACCESS: begin
          if (min_reached_s && rdy_sel_s) begin
            rd_r <= we_r ? {DW{1'b0}} : rd_sel_s;
          end else if (timed_out_s) begin
            err_r <= 1'b1;
            rd_r  <= ERR_DATA;
          end
        end
        default: begin
          rd_r <= rd_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mioc_ws.sv
// Self-checking bench for mioc_ws: directed plus randomized accesses against a
// transaction-level model (expected stall length, read word and error per access).
module tb_mioc_ws;

  localparam int MW_A = 1;
  localparam int TO_A = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        ce_a, ce_b, mem_wr;
  logic [31:0] mem_addr, wt_data, ram_rd;

  logic [31:0]  rd_a, ram_addr_a, ram_wt_a, io_addr_a, io_wt_a;
  logic         stall_a, err_a, ram_ce_a, ram_we_a, io_we_a;
  logic [3:0]   io_ce_a, io_rdy_a;
  logic [127:0] io_rd_a;

  logic [31:0]  rd_b, ram_addr_b, ram_wt_b, io_addr_b, io_wt_b;
  logic         stall_b, err_b, ram_ce_b, ram_we_b, io_we_b;
  logic [2:0]   io_ce_b, io_rdy_b;
  logic [95:0]  io_rd_b;

  int total, passed, fails;

  mioc_ws #(.NUM_CH(4), .MIN_WAIT(MW_A), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .rst(rst), .memCe(ce_a), .memWr(mem_wr), .memAddr(mem_addr),
    .wtData(wt_data), .rdData(rd_a), .memStall(stall_a), .memErr(err_a),
    .ramCe(ram_ce_a), .ramWe(ram_we_a), .ramAddr(ram_addr_a), .ramWtData(ram_wt_a),
    .ramRdData(ram_rd), .ioCe(io_ce_a), .ioWe(io_we_a), .ioAddr(io_addr_a),
    .ioWtData(io_wt_a), .ioRdData(io_rd_a), .ioRdy(io_rdy_a)
  );

  mioc_ws #(.NUM_CH(3), .MIN_WAIT(0), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .memCe(ce_b), .memWr(mem_wr), .memAddr(mem_addr),
    .wtData(wt_data), .rdData(rd_b), .memStall(stall_b), .memErr(err_b),
    .ramCe(ram_ce_b), .ramWe(ram_we_b), .ramAddr(ram_addr_b), .ramWtData(ram_wt_b),
    .ramRdData(ram_rd), .ioCe(io_ce_b), .ioWe(io_we_b), .ioAddr(io_addr_b),
    .ioWtData(io_wt_b), .ioRdData(io_rd_b), .ioRdy(io_rdy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One RAM access on dut_a: every RAM-side effect is visible in the same cycle.
  task automatic ram_access(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                            input logic [31:0] rdv);
    ce_a = 1'b1; mem_wr = wr; mem_addr = addr; wt_data = wd; ram_rd = rdv;
    #1;
    chk("ram_ce", ram_ce_a, 32'd1);
    chk("ram_we", ram_we_a, 32'(wr));
    chk("ram_addr", ram_addr_a, addr);
    chk("ram_wdata", ram_wt_a, wd);
    chk("ram_rddata", rd_a, rdv);
    chk("ram_stall", stall_a, 32'd0);
    chk("ram_ioce", io_ce_a, 32'd0);
  endtask

  // One IO access on dut_a; device on the selected channel becomes ready at
  // ACCESS cycle rdy_start (0-based). Entered and left just after a rising edge.
  task automatic io_access(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                           input int rdy_start, input bit drop_ce);
    int ch, eff, n;
    logic exp_err;
    logic [31:0] exp_d;
    logic [31:0] chd [4];
    logic [3:0] r;
    ch = int'(addr[9:8]);
    for (int k = 0; k < 4; k++) begin
      chd[k] = $urandom;
      io_rd_a[k*32 +: 32] = chd[k];
    end
    eff = (rdy_start > MW_A) ? rdy_start : MW_A;
    if (eff <= TO_A - 1) begin
      n = eff + 1; exp_err = 1'b0; exp_d = we ? 32'd0 : chd[ch];
    end else begin
      n = TO_A; exp_err = 1'b1; exp_d = ERR;
    end
    ce_a = 1'b1; mem_wr = we; mem_addr = addr; wt_data = wd;
    for (int c = 0; c <= n + 1; c++) begin
      r = 4'($urandom);
      r[ch] = (c >= 1) && (c - 1 >= rdy_start);
      io_rdy_a = r;
      if (drop_ce && c >= 2) begin
        ce_a = 1'b0; mem_addr = $urandom; wt_data = $urandom;
      end
      @(negedge clk);
      if (c <= n) begin
        chk("io_stall", stall_a, 32'd1);
        chk("io_err_early", err_a, 32'd0);
        if (c >= 1) begin
          chk("io_ce", io_ce_a, 32'd1 << ch);
          chk("io_we", io_we_a, 32'(we));
          chk("io_addr", io_addr_a, addr);
          chk("io_wdata", io_wt_a, wd);
        end else begin
          chk("io_ce_idle", io_ce_a, 32'd0);
        end
      end else begin
        chk("done_stall", stall_a, 32'd0);
        chk("done_err", err_a, 32'(exp_err));
        chk("done_rddata", rd_a, exp_d);
        chk("done_ioce", io_ce_a, 32'd0);
      end
      @(posedge clk); #1;
    end
    ce_a = 1'b0;
    @(negedge clk);
    chk("after_stall", stall_a, 32'd0);
    chk("after_err", err_a, 32'd0);
    chk("after_ioce", io_ce_a, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] dv [3];
    total = 0; passed = 0; fails = 0;
    rst = 1'b1; ce_a = 1'b0; ce_b = 1'b0; mem_wr = 1'b0;
    mem_addr = 32'd0; wt_data = 32'd0; ram_rd = 32'd0;
    io_rdy_a = 4'd0; io_rd_a = 128'd0; io_rdy_b = 3'd0; io_rd_b = 96'd0;

    // Reset values, even with an IO request present.
    repeat (2) @(negedge clk);
    ce_a = 1'b1; mem_addr = 32'h7000_0100;
    #1;
    chk("rst_stall", stall_a, 32'd0);
    chk("rst_err", err_a, 32'd0);
    chk("rst_rddata", rd_a, 32'd0);
    chk("rst_ioce", io_ce_a, 32'd0);
    chk("rst_ioaddr", io_addr_a, 32'd0);
    ce_a = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // RAM path, directed then random.
    ram_access(32'h0000_0040, 1'b0, 32'h0, 32'h1234_5678);
    ram_access(32'h8000_0010, 1'b1, 32'h5555_AAAA, 32'h0BAD_F00D);
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      if (a[31:28] == 4'h7) a[31:28] = 4'h3;
      ram_access(a, 1'($urandom), $urandom, $urandom);
    end
    ce_a = 1'b0; mem_addr = 32'h0000_0040; #1;
    chk("noce_ramce", ram_ce_a, 32'd0);
    chk("noce_ramaddr", ram_addr_a, 32'd0);
    chk("noce_rddata", rd_a, 32'd0);
    @(posedge clk); #1;

    // IO directed: fast write, slow read, timeout, last-cycle ready, dropped memCe.
    io_access(32'h7000_0104, 1'b1, 32'hA5A5_A5A5, 0, 1'b0);
    io_access(32'h7000_0300, 1'b0, 32'h0, 5, 1'b0);
    io_access(32'h7000_0200, 1'b0, 32'h0, 1000, 1'b0);
    io_access(32'h7000_0000, 1'b0, 32'h0, TO_A - 1, 1'b0);
    io_access(32'h7000_0100, 1'b1, 32'h1357_9BDF, TO_A, 1'b0);
    io_access(32'h7000_0200, 1'b0, 32'h0, 3, 1'b1);

    // IO random.
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      a[31:28] = 4'h7;
      io_access(a, 1'($urandom), $urandom, ($urandom_range(0, 4) == 0) ? 100 : int'($urandom_range(0, 9)), 1'($urandom));
    end

    // Reset in the second ACCESS cycle aborts at once.
    ce_a = 1'b1; mem_wr = 1'b0; mem_addr = 32'h7000_0200; io_rdy_a = 4'd0;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_rst_ioce", io_ce_a, 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ioce", io_ce_a, 32'd0);
    chk("mid_rst_stall", stall_a, 32'd0);
    chk("mid_rst_err", err_a, 32'd0);
    ce_a = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    ram_access(32'h0000_0080, 1'b0, 32'h0, 32'h2468_ACE0);
    @(negedge clk);
    chk("post_rst_ioce", io_ce_a, 32'd0);
    chk("post_rst_err", err_a, 32'd0);
    @(posedge clk); #1;
    ce_a = 1'b0;
    io_access(32'h7000_0300, 1'b0, 32'h0, 2, 1'b0);

    // dut_b: bad channel 3 of 3 goes straight to DONE with an error.
    ce_b = 1'b1; mem_wr = 1'b0; mem_addr = 32'h7000_0300;
    @(negedge clk);
    chk("bad_stall_idle", stall_b, 32'd1);
    chk("bad_ioce_idle", io_ce_b, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bad_stall_done", stall_b, 32'd0);
    chk("bad_err", err_b, 32'd1);
    chk("bad_rddata", rd_b, ERR);
    chk("bad_ioce_done", io_ce_b, 32'd0);
    @(posedge clk); #1;
    ce_b = 1'b0;
    @(negedge clk);
    chk("bad_err_after", err_b, 32'd0);
    @(posedge clk); #1;

    // dut_b: MIN_WAIT=0 with ready high gives back-to-back 3-cycle accesses.
    for (int k = 0; k < 3; k++) begin
      dv[k] = $urandom;
      io_rd_b[k*32 +: 32] = dv[k];
    end
    io_rdy_b = 3'b111; ce_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_addr = (i == 0) ? 32'h7000_0200 : 32'h7000_0000;
      @(negedge clk);
      chk("b2b_stall_idle", stall_b, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("b2b_stall_acc", stall_b, 32'd1);
      chk("b2b_ioce", io_ce_b, (i == 0) ? 32'd4 : 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("b2b_stall_done", stall_b, 32'd0);
      chk("b2b_err", err_b, 32'd0);
      chk("b2b_rddata", rd_b, (i == 0) ? dv[2] : dv[0]);
      @(posedge clk); #1;
    end
    ce_b = 1'b0;
    @(negedge clk);
    chk("b2b_after_stall", stall_b, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
